// File: rtl/tl_pkg.sv
// Shared state encodings and sizing helper for the multiphase traffic-light controller.
package tl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_GREEN  = 3'd1;
    localparam logic [2:0] ST_YELLOW = 3'd2;
    localparam logic [2:0] ST_ALLRED = 3'd3;
    localparam logic [2:0] ST_FLASH  = 3'd4;

    // Width of the approach index; never below one bit so a port always exists.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Phase tick counter: clears on state entry, counts tick_en pulses, flags the final tick.
module tl_phase_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             tick_en,
    input  logic [CNT_W-1:0] last,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (tick_en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign done = tick_en && (cnt == last);

endmodule

// File: rtl/tl_multiphase_ctrl.sv
// Round-robin traffic-light phase controller with pedestrian truncation, walk and flash mode.
module tl_multiphase_ctrl import tl_pkg::*; #(
    parameter int N_DIR       = 2,
    parameter int CNT_W       = 6,
    parameter int T_GREEN     = 20,
    parameter int T_MIN_GREEN = 5,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_en,
    input  logic                    start,
    input  logic                    force_flash,
    input  logic [N_DIR-1:0]        ped_req,
    output logic [N_DIR-1:0]        red,
    output logic [N_DIR-1:0]        yellow,
    output logic [N_DIR-1:0]        green,
    output logic [N_DIR-1:0]        walk,
    output logic [idx_w(N_DIR)-1:0] phase_idx,
    output logic [N_DIR-1:0]        ped_pend
);

    localparam int IDX_W = idx_w(N_DIR);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIR - 1);

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_DIR-1:0] pend_q, pend_d;
    logic             walk_q, toggle_q;
    logic [CNT_W-1:0] cnt, last;
    logic             done;
    logic [N_DIR-1:0] own;
    logic             other_pend;

    tl_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_d != state_q),
        .tick_en (tick_en),
        .last    (last),
        .cnt     (cnt),
        .done    (done)
    );

    always_comb begin
        last = CNT_W'(T_GREEN - 1);
        case (state_q)
            ST_YELLOW: last = CNT_W'(T_YELLOW - 1);
            ST_ALLRED: last = CNT_W'(T_ALLRED - 1);
            default:   last = CNT_W'(T_GREEN - 1);
        endcase
    end

    always_comb begin
        own         = '0;
        own[idx_q]  = 1'b1;
        other_pend  = |(pend_q & ~own);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (force_flash) begin
            state_d = ST_FLASH;
        end else if (state_q == ST_FLASH) begin
            state_d = ST_ALLRED;
        end else if (!start) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (tick_en) state_d = ST_GREEN;
                ST_GREEN: begin
                    if (done || (tick_en && other_pend &&
                                 cnt >= CNT_W'(T_MIN_GREEN - 1))) begin
                        state_d = ST_YELLOW;
                    end
                end
                ST_YELLOW: if (done) state_d = ST_ALLRED;
                ST_ALLRED: begin
                    if (done) begin
                        state_d = ST_GREEN;
                        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A request held high across its own served green stays pending for the next round.
    always_comb begin
        pend_d = pend_q | ped_req;
        if (state_q == ST_GREEN && state_d == ST_YELLOW) begin
            pend_d[idx_q] = ped_req[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            pend_q   <= '0;
            walk_q   <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            if (state_d == ST_GREEN && state_q != ST_GREEN) begin
                walk_q <= pend_d[idx_d];
            end
            if (state_d == ST_FLASH && state_q != ST_FLASH) begin
                toggle_q <= 1'b1;
            end else if (state_q == ST_FLASH && tick_en) begin
                toggle_q <= ~toggle_q;
            end
        end
    end

    always_comb begin
        red    = '1;
        yellow = '0;
        green  = '0;
        walk   = '0;
        case (state_q)
            ST_GREEN: begin
                red[idx_q]   = 1'b0;
                green[idx_q] = 1'b1;
                walk[idx_q]  = walk_q;
            end
            ST_YELLOW: begin
                red[idx_q]    = 1'b0;
                yellow[idx_q] = 1'b1;
            end
            ST_FLASH: begin
                red    = '0;
                yellow = {N_DIR{toggle_q}};
            end
            default: ;
        endcase
    end

    assign phase_idx = idx_q;
    assign ped_pend  = pend_q;

endmodule
